// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StHi,
    StLo,
    StCksum,
    StRun
  } state_e;

  localparam logic [7:0] HDR_IMEM_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR_DMEM_DEFAULT = 8'h5A;

  localparam logic MEMSEL_IMEM = 1'b0;
  localparam logic MEMSEL_DMEM = 1'b1;

endpackage

// File: rtl/prog_loader.sv
// Decodes framed packets from a valid/ready byte stream into 16-bit memory writes,
// then hands the CPU control until it reports halt.
module prog_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter logic [7:0]  HDR_IMEM = prog_loader_pkg::HDR_IMEM_DEFAULT,
  parameter logic [7:0]  HDR_DMEM = prog_loader_pkg::HDR_DMEM_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              mem_we_o,
  output logic              mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              do_halt_i,
  output logic              cpu_run_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  import prog_loader_pkg::*;

  state_e            state_q, state_d;
  logic              xfer;
  logic              is_hdr;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  assign xfer   = rx_valid_i && rx_ready_o;
  assign is_hdr = (rx_data_i == HDR_IMEM) || (rx_data_i == HDR_DMEM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (xfer && is_hdr) state_d = StCount;
      StCount: if (xfer) state_d = StHi;
      StHi:    if (xfer) state_d = StLo;
      StLo:    if (xfer) state_d = (addr_q == last_q) ? StCksum : StHi;
      StCksum: if (xfer) state_d = (rx_data_i == chk_q) ? StRun : StIdle;
      StRun:   if (do_halt_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_ready_o  = 1'b1;
    cpu_run_o   = 1'b0;
    load_busy_o = 1'b0;
    unique case (state_q)
      StCount, StHi, StLo, StCksum: load_busy_o = 1'b1;
      StRun: begin
        rx_ready_o = 1'b0;
        cpu_run_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: packet bookkeeping plus the registered write port.
  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    last_d  = last_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (is_hdr) begin
            sel_d = (rx_data_i == HDR_DMEM) ? MEMSEL_DMEM : MEMSEL_IMEM;
            err_d = 1'b0;
          end
        end
        StCount: begin
          // Count 0 wraps to all-ones, i.e. a full 2**ADDR_W word packet.
          last_d = ADDR_W'(rx_data_i) - ADDR_W'(1);
          chk_d  = rx_data_i;
          addr_d = '0;
        end
        StHi: begin
          hi_d  = rx_data_i;
          chk_d = chk_q ^ rx_data_i;
        end
        StLo: begin
          chk_d   = chk_q ^ rx_data_i;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, rx_data_i};
          addr_d  = addr_q + ADDR_W'(1);
        end
        StCksum: begin
          if (rx_data_i == chk_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= MEMSEL_IMEM;
      addr_q  <= '0;
      last_q  <= '0;
      chk_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_sel_o   = sel_q;
  assign mem_addr_o  = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Byte-stream program loader that writes the CPU memories before execution and returns control once the CPU halts. It takes bytes from a valid/ready source (UART receiver or bench driver) and decodes a framed packet. It streams 16-bit words into the instruction memory (fetch stage) or the data memory (memory stage) through a write port. After a good checksum it releases the core (cpu_run=1). When do_halt is seen it takes the core back and waits for the next packet.

Parameters:
ADDR_W, 8, memory word-address width; max words per packet = 2**ADDR_W
DATA_W, 16, memory word width (fixed 16; two bytes per word)
HDR_IMEM, 8'hA5, header byte selecting instruction memory
HDR_DMEM, 8'h5A, header byte selecting data memory

Ports:
CLK  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready
mem_we  out  1  one-cycle write strobe
mem_sel  out  1  0 = instruction memory, 1 = data memory
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  word to write
do_halt  in  1  CPU halt indication (level)
cpu_run  out  1  1 = CPU released from loader control
load_busy  out  1  packet in progress (states COUNT..CKSUM)
load_done  out  1  one-cycle pulse on good checksum
load_err  out  1  sticky checksum error; cleared by next accepted header

Behaviour:
- Packet format: header, count C, then N words sent high byte first, then checksum.
  - N = C, except C = 0 means 2**ADDR_W.
  - Checksum = XOR of the count byte and every data byte (header excluded).
- Reset (rst=0, async): state IDLE; every output 0 except rx_ready=1; addr, count and checksum registers cleared.
- States and transitions:
  - IDLE: header byte -> COUNT, latch mem_sel, clear load_err. Any other byte is dropped silently.
  - COUNT: latch N, set chk=byte, addr=0 -> HI.
  - HI: latch high byte, chk ^= byte -> LO.
  - LO: chk ^= byte, issue write -> HI, or -> CKSUM after the N-th word.
  - CKSUM: if byte == chk -> RUN, pulse load_done. Else -> IDLE, set load_err, cpu_run stays 0.
  - RUN: rx_ready=0 and cpu_run=1. do_halt=1 -> IDLE, cpu_run=0 the following cycle.
- rx_ready: 1 in every state except RUN. It is a registered/state decode only, never combinational from rx_valid.
- Write timing:
  - mem_we, mem_addr and mem_wdata are registered.
  - The strobe appears the cycle after the LO byte transfer, with mem_wdata = {hi,lo}.
  - mem_addr increments after each write. Address N-1 is the last write; no wrap within a packet.
- Words are written as they arrive. A checksum failure does not undo writes; it only withholds cpu_run.
- Back-to-back bytes (rx_valid held high) are accepted every cycle with no bubbles.
- A header byte arriving mid-packet is treated as data; there is no resync.
- do_halt outside RUN is ignored.
- cpu_run changes only on a clock edge or on reset.
- A reset mid-packet aborts the packet; a partial memory image is left, cpu_run=0.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, COUNT, HI, LO, CKSUM, RUN);
  - the header constants;
  - the memory-select encoding (MEMSEL_IMEM=0, MEMSEL_DMEM=1).
- Single module; no sub-module. Checksum and word assembly are a few registers.
- CPU top-level integration: cpu_run gates the core's reset/stall. The fetch and memory stages expose a write port muxed with their internal access while cpu_run=0.

Test Plan:
1. Send A5 02 51 01 FF FF 52.
   - Writes imem[0]=16'h5101, then imem[1]=16'hFFFF.
   - load_done pulses once; cpu_run=1 the cycle after the 52 byte; load_err=0.
2. Send 5A 02 75 30 00 0A 4D.
   - dmem[0]=30000 (16'h7530) and dmem[1]=10, mem_sel=1.
   - cpu_run=1.
3. Same as test 1 but checksum 53.
   - Both writes occur, load_err=1, cpu_run=0, state back in IDLE.
   - A following good packet clears load_err.
4. In RUN, drive rx_valid with A5.
   - rx_ready=0 and no transfer.
   - Pulse do_halt=1 for one cycle: cpu_run=0 next cycle, rx_ready=1, and a new load succeeds.
5. Send 3C 00 A5 01 12 34 27 with rx_valid held continuously.
   - 3C and 00 are dropped; one write imem[0]=16'h1234.
   - Exactly 5 transfers after the two dropped bytes; load_done pulses.
6. Drive rst=0 asynchronously after A5 02 51.
   - All outputs reset immediately without waiting for a clock edge.
   - After release the next A5 starts a fresh packet at addr 0.
